// File: rtl/spatz_pkg.sv
// Shared Spatz types used by the vector-register hazard scoreboard.
package spatz_pkg;

  // Architectural vector registers and VRF port address layout.
  // The register index sits in the upper bits. The lower bits select an element offset.
  localparam int unsigned SpatzNrVRegs   = 32;
  localparam int unsigned VRegIdxWidth   = $clog2(SpatzNrVRegs);
  localparam int unsigned VRegOffWidth   = 5;
  localparam int unsigned VRegAddrWidth  = VRegIdxWidth + VRegOffWidth;

  typedef logic [VRegAddrWidth-1:0] vreg_addr_t;
  typedef logic [VRegIdxWidth-1:0]  vreg_idx_t;

  // Default number of instructions the scoreboard can track at once.
  localparam int unsigned SpatzNrSbInsn  = 8;

  typedef logic [$clog2(SpatzNrSbInsn)-1:0] sb_id_t;

  // Operand footprint of one in-flight instruction.
  typedef struct packed {
    vreg_idx_t       vd;
    logic            vd_valid;
    vreg_idx_t [1:0] vs;
    logic      [1:0] vs_valid;
  } sb_entry_t;

  // Direction of a VRF port access.
  typedef enum logic {
    SbRead  = 1'b0,
    SbWrite = 1'b1
  } sb_access_e;

endpackage

// File: rtl/spatz_sb_hazard_check.sv
// Per-port hazard detector. It scans the older instructions an access depends on.
// A read is blocked by an older pending writer of the same register (RAW).
// A write is blocked by an older pending reader of the same register (WAR).
module spatz_sb_hazard_check
  import spatz_pkg::*;
#(
  parameter int unsigned NrInsn = SpatzNrSbInsn
) (
  input  logic      [NrInsn-1:0] dep_i,
  input  sb_entry_t [NrInsn-1:0] entries_i,
  input  vreg_idx_t              reg_i,
  input  sb_access_e             access_i,
  output logic                   block_o
);

  // OR-reduce the conflicts over every older instruction this access depends on.
  always_comb begin
    // NOTE: default assigned before any conditional update so no latch is inferred.
    block_o = 1'b0;
    for (int unsigned j = 0; j < NrInsn; j++) begin
      if (dep_i[j]) begin
        if (access_i == SbRead) begin
          if (entries_i[j].vd_valid && (entries_i[j].vd == reg_i)) begin
            // NOTE: blocking assignments in combinational logic; the value accumulates in order.
            block_o = 1'b1;
          end
        end else begin
          for (int unsigned k = 0; k < 2; k++) begin
            if (entries_i[j].vs_valid[k] && (entries_i[j].vs[k] == reg_i)) begin
              block_o = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/spatz_vreg_scoreboard.sv
// Vector-register hazard scoreboard. It tracks in-flight instructions by ID and
// gates every VRF port enable to resolve RAW/WAR hazards. WAW hazards stall at issue.
// Port vectors are the concatenation {writes, reads]: indices below NrReadPorts
// are read ports, and the rest are write ports.
module spatz_vreg_scoreboard
  import spatz_pkg::*;
#(
  parameter int unsigned NrReadPorts  = 5,
  parameter int unsigned NrWritePorts = 3,
  parameter int unsigned NrInsn       = SpatzNrSbInsn,
  parameter int unsigned NrVRegs      = SpatzNrVRegs,
  parameter int unsigned AddrWidth    = $bits(vreg_addr_t)
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  // Issue
  input  logic                                                   issue_valid_i,
  output logic                                                   issue_ready_o,
  input  logic [$clog2(NrVRegs)-1:0]                             issue_vd_i,
  input  logic                                                   issue_vd_valid_i,
  input  logic [1:0][$clog2(NrVRegs)-1:0]                        issue_vs_i,
  input  logic [1:0]                                             issue_vs_valid_i,
  output logic [$clog2(NrInsn)-1:0]                              issue_id_o,
  // Retire
  input  logic                                                   retire_valid_i,
  input  logic [$clog2(NrInsn)-1:0]                              retire_id_i,
  // VRF ports
  input  logic [NrWritePorts+NrReadPorts-1:0][AddrWidth-1:0]     port_addr_i,
  input  logic [NrWritePorts+NrReadPorts-1:0][$clog2(NrInsn)-1:0] port_id_i,
  input  logic [NrWritePorts+NrReadPorts-1:0]                    port_enable_i,
  output logic [NrWritePorts+NrReadPorts-1:0]                    port_enable_o,
  output logic                                                   busy_o
);

  localparam int unsigned NrPorts  = NrWritePorts + NrReadPorts;
  localparam int unsigned IdWidth  = $clog2(NrInsn);
  localparam int unsigned RegWidth = $clog2(NrVRegs);

  // Per-ID state
  logic      [NrInsn-1:0]             inflight_q, inflight_d;
  sb_entry_t [NrInsn-1:0]             entries_q,  entries_d;
  logic      [NrInsn-1:0][NrInsn-1:0] dep_q,      dep_d;

  // Derived state
  logic [NrVRegs-1:0] wr_pending;
  logic [IdWidth-1:0] free_id;
  logic               any_free;
  logic               issue_hs;
  logic               retire_hs;

  // Only the register index of a port address matters for hazards.
  logic unused_addr_bits;
  assign unused_addr_bits = ^port_addr_i;

  // Pick the lowest free ID from registered state.
  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = NrInsn - 1; i >= 0; i--) begin
      if (!inflight_q[i]) begin
        free_id  = IdWidth'(i);
        any_free = 1'b1;
      end
    end
  end

  // Mark each register that has a pending in-flight writer.
  always_comb begin
    wr_pending = '0;
    for (int unsigned i = 0; i < NrInsn; i++) begin
      if (inflight_q[i] && entries_q[i].vd_valid) begin
        wr_pending[entries_q[i].vd] = 1'b1;
      end
    end
  end

  // WAW hazards stall at issue, so each register has at most one pending writer.
  assign issue_ready_o = any_free && !(issue_vd_valid_i && wr_pending[issue_vd_i]);
  assign issue_id_o    = free_id;
  assign busy_o        = |inflight_q;
  assign issue_hs      = issue_valid_i && issue_ready_o;
  // A retire for an ID that is not in flight has no effect.
  assign retire_hs     = retire_valid_i && inflight_q[retire_id_i];

  // Next-state: apply the retire, then register the newly issued instruction.
  always_comb begin
    inflight_d = inflight_q;
    entries_d  = entries_q;
    dep_d      = dep_q;

    if (retire_hs) begin
      inflight_d[retire_id_i] = 1'b0;
      for (int unsigned k = 0; k < NrInsn; k++) begin
        dep_d[k][retire_id_i] = 1'b0;
      end
    end

    if (issue_hs) begin
      inflight_d[free_id]         = 1'b1;
      entries_d[free_id].vd       = issue_vd_i;
      entries_d[free_id].vd_valid = issue_vd_valid_i;
      entries_d[free_id].vs       = issue_vs_i;
      entries_d[free_id].vs_valid = issue_vs_valid_i;
      // Every instruction in flight is older. The free slot's own bit is already 0.
      dep_d[free_id]              = inflight_q;
      if (retire_hs) begin
        dep_d[free_id][retire_id_i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      // NOTE: the small entry array is reset as well, so no X can reach the hazard compare.
      entries_q  <= '0;
      dep_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      inflight_q <= inflight_d;
      entries_q  <= entries_d;
      dep_q      <= dep_d;
    end
  end

  // Gate each VRF port. Untracked IDs pass their enable straight through.
  for (genvar p = 0; p < NrPorts; p++) begin : gen_port
    localparam sb_access_e Access = (p < NrReadPorts) ? SbRead : SbWrite;

    logic block;

    spatz_sb_hazard_check #(
      .NrInsn (NrInsn)
    ) i_hazard_check (
      .dep_i     (dep_q[port_id_i[p]]),
      .entries_i (entries_q),
      .reg_i     (port_addr_i[p][AddrWidth-1 -: RegWidth]),
      .access_i  (Access),
      .block_o   (block)
    );

    assign port_enable_o[p] = port_enable_i[p] && !(inflight_q[port_id_i[p]] && block);
  end

  // A retire must name an in-flight instruction.
  retire_inflight_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire_valid_i |-> inflight_q[retire_id_i]);

endmodule

// File: tb/tb_spatz_vreg_scoreboard.sv
// Self-checking bench for spatz_vreg_scoreboard. Directed scenarios are followed
// by a random phase, with every cycle checked against an age-ordered reference model.
module tb_spatz_vreg_scoreboard;
  import spatz_pkg::*;

  localparam int NR = 5;
  localparam int NW = 3;
  localparam int NP = NR + NW;
  localparam int NI = 8;
  localparam int AW = $bits(vreg_addr_t);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [4:0]           issue_vd;
  logic                 issue_vd_valid;
  logic [1:0][4:0]      issue_vs;
  logic [1:0]           issue_vs_valid;
  logic [2:0]           issue_id;
  logic                 retire_valid;
  logic [2:0]           retire_id;
  logic [NP-1:0][AW-1:0] port_addr;
  logic [NP-1:0][2:0]   port_id;
  logic [NP-1:0]        port_en;
  logic [NP-1:0]        port_en_o;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  // Reference model: each live instruction has an issue sequence number.
  // An instruction depends on every live instruction with a smaller number.
  bit m_inf [NI];
  int m_vd  [NI];
  bit m_vdv [NI];
  int m_vs  [NI][2];
  bit m_vsv [NI][2];
  int m_seq [NI];
  int seq_ctr = 0;

  always #5 clk = ~clk;

  spatz_vreg_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_vd_i       (issue_vd),
    .issue_vd_valid_i (issue_vd_valid),
    .issue_vs_i       (issue_vs),
    .issue_vs_valid_i (issue_vs_valid),
    .issue_id_o       (issue_id),
    .retire_valid_i   (retire_valid),
    .retire_id_i      (retire_id),
    .port_addr_i      (port_addr),
    .port_id_i        (port_id),
    .port_enable_i    (port_en),
    .port_enable_o    (port_en_o),
    .busy_o           (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free_id();
    for (int i = 0; i < NI; i++) if (!m_inf[i]) return i;
    return -1;
  endfunction

  function automatic bit m_ready(int vd, bit vdv);
    if (m_free_id() < 0) return 1'b0;
    if (vdv) for (int i = 0; i < NI; i++) if (m_inf[i] && m_vdv[i] && m_vd[i] == vd) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_grant(int p);
    int t;
    int x;
    if (!port_en[p]) return 1'b0;
    t = int'(port_id[p]);
    x = int'(port_addr[p][AW-1 -: 5]);
    if (!m_inf[t]) return 1'b1;
    for (int j = 0; j < NI; j++) begin
      if (m_inf[j] && m_seq[j] < m_seq[t]) begin
        if (p < NR) begin
          if (m_vdv[j] && m_vd[j] == x) return 1'b0;
        end else begin
          for (int k = 0; k < 2; k++) if (m_vsv[j][k] && m_vs[j][k] == x) return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NI; i++) m_inf[i] = 1'b0;
  endtask

  task automatic check_all();
    logic [NP-1:0] exp_en;
    bit any;
    any = 1'b0;
    for (int i = 0; i < NI; i++) any |= m_inf[i];
    check("issue_ready", issue_ready, m_ready(issue_vd, issue_vd_valid));
    check("busy", busy, any);
    if (m_free_id() >= 0) check("issue_id", issue_id, m_free_id());
    for (int p = 0; p < NP; p++) exp_en[p] = m_grant(p);
    check("port_enable", port_en_o, exp_en);
  endtask

  task automatic peek();
    #1;
  endtask

  // Check the settled outputs, take the clock edge, and update the model. Returns at the falling edge.
  task automatic tick();
    bit hs;
    bit rv;
    int nid;
    #1;
    check_all();
    hs  = issue_valid && m_ready(issue_vd, issue_vd_valid);
    rv  = retire_valid && m_inf[retire_id];
    nid = m_free_id();
    @(posedge clk);
    if (rv) m_inf[retire_id] = 1'b0;
    if (hs) begin
      m_inf[nid] = 1'b1;
      m_vd[nid]  = issue_vd;
      m_vdv[nid] = issue_vd_valid;
      for (int k = 0; k < 2; k++) begin
        m_vs[nid][k]  = issue_vs[k];
        m_vsv[nid][k] = issue_vs_valid[k];
      end
      seq_ctr++;
      m_seq[nid] = seq_ctr;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_vd       = '0;
    issue_vd_valid = 1'b0;
    issue_vs       = '0;
    issue_vs_valid = '0;
    retire_valid   = 1'b0;
    retire_id      = '0;
    port_addr      = '0;
    port_id        = '0;
    port_en        = '0;
  endtask

  task automatic set_port(input int p, input int id, input int r, input bit en);
    port_id[p]   = 3'(id);
    port_addr[p] = {5'(r), 5'($urandom_range(0, 31))};
    port_en[p]   = en;
  endtask

  task automatic set_issue(input int vd, input bit vdv, input int vs0, input bit v0,
                           input int vs1, input bit v1);
    issue_valid       = 1'b1;
    issue_vd          = 5'(vd);
    issue_vd_valid    = vdv;
    issue_vs[0]       = 5'(vs0);
    issue_vs[1]       = 5'(vs1);
    issue_vs_valid[0] = v0;
    issue_vs_valid[1] = v1;
  endtask

  task automatic do_issue(input int vd, input bit vdv, input int vs0, input bit v0);
    set_issue(vd, vdv, vs0, v0, 0, 1'b0);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_retire(input int id);
    retire_valid = 1'b1;
    retire_id    = 3'(id);
    tick();
    retire_valid = 1'b0;
  endtask

  initial begin
    int live[$];
    idle();
    m_clear();

    // Reset state
    #12;
    check("rst_ready", issue_ready, 1);
    check("rst_id", issue_id, 0);
    check("rst_busy", busy, 0);
    check("rst_en_zero", port_en_o, 8'h00);
    for (int p = 0; p < NP; p++) set_port(p, p, p, 1'b1);
    #1;
    check("rst_en_pass", port_en_o, 8'hff);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Issue vd=3, then a read by ID0 on v3 is granted
    set_issue(3, 1'b1, 0, 1'b0, 0, 1'b0);
    peek();
    check("t1_id", issue_id, 0);
    tick();
    issue_valid = 1'b0;
    set_port(3, 0, 3, 1'b1);
    peek();
    check("t1_busy", busy, 1);
    check("t1_rd_own", port_en_o[3], 1);
    tick();
    idle();
    do_retire(0);

    // RAW: ID0 writes v4, ID1 reads v4
    do_issue(4, 1'b1, 0, 1'b0);
    set_issue(0, 1'b0, 4, 1'b1, 0, 1'b0);
    peek();
    check("raw_id1", issue_id, 1);
    tick();
    issue_valid = 1'b0;
    set_port(0, 1, 4, 1'b1);
    peek();
    check("raw_block", port_en_o[0], 0);
    retire_valid = 1'b1;
    retire_id    = 3'd0;
    peek();
    check("raw_block_retire_cyc", port_en_o[0], 0);
    tick();
    retire_valid = 1'b0;
    peek();
    check("raw_grant_after", port_en_o[0], 1);
    tick();
    idle();
    do_retire(1);

    // WAR: ID0 reads v5, ID1 writes v5
    do_issue(0, 1'b0, 5, 1'b1);
    do_issue(5, 1'b1, 0, 1'b0);
    set_port(NR, 1, 5, 1'b1);
    set_port(0, 0, 5, 1'b1);
    peek();
    check("war_block", port_en_o[NR], 0);
    check("war_own_read", port_en_o[0], 1);
    do_retire(0);
    peek();
    check("war_grant_after", port_en_o[NR], 1);
    tick();
    idle();
    do_retire(1);

    // WAW: a second writer of v7 stalls, even while the first one retires
    do_issue(7, 1'b1, 0, 1'b0);
    set_issue(7, 1'b1, 0, 1'b0, 0, 1'b0);
    peek();
    check("waw_stall", issue_ready, 0);
    retire_valid = 1'b1;
    retire_id    = 3'd0;
    peek();
    check("waw_stall_retire_cyc", issue_ready, 0);
    tick();
    retire_valid = 1'b0;
    peek();
    check("waw_ready_after", issue_ready, 1);
    check("waw_id_after", issue_id, 0);
    tick();
    idle();
    do_retire(0);

    // Fill all slots, then issue and retire together
    for (int i = 0; i < NI; i++) begin
      set_issue(8 + i, 1'b1, 0, 1'b0, 0, 1'b0);
      peek();
      check("fill_id", issue_id, i);
      tick();
    end
    idle();
    peek();
    check("full_ready", issue_ready, 0);
    set_issue(20, 1'b1, 0, 1'b0, 0, 1'b0);
    retire_valid = 1'b1;
    retire_id    = 3'd5;
    peek();
    check("full_retire_cyc_ready", issue_ready, 0);
    tick();
    idle();
    peek();
    check("full_ready_next", issue_ready, 1);
    check("full_id_next", issue_id, 5);
    tick();

    // Asynchronous reset with four instructions in flight and ports blocked
    do_retire(4);
    do_retire(6);
    do_retire(7);
    set_port(0, 3, 8, 1'b1);
    set_port(1, 2, 9, 1'b1);
    peek();
    check("pre_rst_block0", port_en_o[0], 0);
    check("pre_rst_block1", port_en_o[1], 0);
    #1;
    rst_n = 1'b0;
    m_clear();
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", issue_ready, 1);
    check("arst_pass", port_en_o, 8'h03);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Random traffic checked against the model every cycle
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      if ($urandom_range(0, 99) < 50) begin
        set_issue($urandom_range(0, 7), $urandom_range(0, 99) < 70,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      end
      live.delete();
      for (int i = 0; i < NI; i++) if (m_inf[i]) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 99) < 40) begin
        retire_valid = 1'b1;
        retire_id    = 3'(live[$urandom_range(0, live.size() - 1)]);
      end
      for (int p = 0; p < NP; p++) begin
        set_port(p, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      end
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
